// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shadow pipeline of post-EX destinations, ALU operand
// forwarding selects, load-use stall and taken-branch flush. Optional HAZ_PERF_CNT_EN adds counters.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_uses_rn,
    input  logic                  id_uses_rm,
    input  logic [REG_ADDR_W-1:0] ex_rn,
    input  logic [REG_ADDR_W-1:0] ex_rm,
    input  logic                  ex_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  br_taken,
    output logic [SEL_W-1:0]      fwd_a,
    output logic [SEL_W-1:0]      fwd_b,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  flush_if_id
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

    logic                  sh_wr [FWD_STAGES];
    logic [REG_ADDR_W-1:0] sh_rd [FWD_STAGES];
    logic                  sh_ld [FWD_STAGES];
    logic [CNT_W-1:0]      stall_cnt;

    logic             hit;
    logic             busy;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;

    assign busy = (stall_cnt != '0);
    assign hit  = ex_is_load & ex_wr_en & (ex_rd != ZERO) & id_valid &
                  ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

    // Scan oldest to youngest so the youngest eligible stage overwrites the select.
    // A load only becomes forwardable once its data has left memory.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (sh_wr[k-1] && (sh_rd[k-1] != ZERO) && (!sh_ld[k-1] || (k >= LOAD_LAT + 1))) begin
                if (sh_rd[k-1] == ex_rn) sel_a = SEL_W'(k);
                if (sh_rd[k-1] == ex_rm) sel_b = SEL_W'(k);
            end
        end
    end

    assign fwd_a       = rst ? '0 : sel_a;
    assign fwd_b       = rst ? '0 : sel_b;
    assign stall_if    = ~rst & ~br_taken & (hit | busy);
    assign bubble_ex   = ~rst & (br_taken | hit | busy);
    assign flush_if_id = ~rst & br_taken;

    // The shadow shifts even while stalling: the bubble enters EX, older work keeps moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                sh_wr[k] <= 1'b0;
                sh_rd[k] <= '0;
                sh_ld[k] <= 1'b0;
            end
            stall_cnt <= '0;
        end else begin
            sh_wr[0] <= ex_wr_en;
            sh_rd[0] <= ex_rd;
            sh_ld[0] <= ex_is_load;
            for (int k = 1; k < FWD_STAGES; k++) begin
                sh_wr[k] <= sh_wr[k-1];
                sh_rd[k] <= sh_rd[k-1];
                sh_ld[k] <= sh_ld[k-1];
            end
            if (br_taken) begin
                stall_cnt <= '0;
            end else if (hit && !busy) begin
                stall_cnt <= CNT_W'(LOAD_LAT - 1);
            end else if (busy) begin
                stall_cnt <= stall_cnt - 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_if && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
            if (flush_if_id && (flush_cycles != 32'hFFFF_FFFF)) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (default and LOAD_LAT=2/FWD_STAGES=3) share
// one vector table; expectations go through a queue and are checked each negedge.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rn, id_uses_rm, ex_wr_en, ex_is_load, br_taken;
    logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd;
    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic       a_st, a_bu, a_fl, b_st, b_bu, b_fl;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    always #5 clk = ~clk;

    hazard_forward_unit u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rn(ex_rn), .ex_rm(ex_rm),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
        .fwd_a(a_fa), .fwd_b(a_fb), .stall_if(a_st), .bubble_ex(a_bu), .flush_if_id(a_fl)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(a_sc), .flush_cycles(a_fc)
`endif
    );

    hazard_forward_unit #(.FWD_STAGES(3), .LOAD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rn(ex_rn), .ex_rm(ex_rm),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
        .fwd_a(b_fa), .fwd_b(b_fb), .stall_if(b_st), .bubble_ex(b_bu), .flush_if_id(b_fl)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(b_sc), .flush_cycles(b_fc)
`endif
    );

    // sbf = {stall_if, bubble_ex, flush_if_id}
    typedef struct {
        int rst, idv, irn, irm, urn, urm, xrn, xrm, wr, rd, ld, br;
        int a_fa, a_fb, a_sbf, b_fa, b_fb, b_sbf;
    } vec_t;

    typedef struct {
        int idx;
        int a_fa, a_fb, a_sbf, b_fa, b_fb, b_sbf;
    } exp_t;

    vec_t vt[27];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic drive(input vec_t v);
        rst        = v.rst[0];
        id_valid   = v.idv[0];
        id_rn      = 5'(v.irn);
        id_rm      = 5'(v.irm);
        id_uses_rn = v.urn[0];
        id_uses_rm = v.urm[0];
        ex_rn      = 5'(v.xrn);
        ex_rm      = 5'(v.xrm);
        ex_wr_en   = v.wr[0];
        ex_rd      = 5'(v.rd);
        ex_is_load = v.ld[0];
        br_taken   = v.br[0];
    endtask

    task automatic check_pop();
        exp_t e;
        int   a_sbf, b_sbf;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        a_sbf = int'({a_st, a_bu, a_fl});
        b_sbf = int'({b_st, b_bu, b_fl});
        if (int'(a_fa) != e.a_fa || int'(a_fb) != e.a_fb || a_sbf != e.a_sbf) begin
            n_err++;
            $display("FAIL vec%0d_dutA: got fa=%0d fb=%0d sbf=%0d, want fa=%0d fb=%0d sbf=%0d",
                     e.idx, a_fa, a_fb, a_sbf, e.a_fa, e.a_fb, e.a_sbf);
        end
        if (int'(b_fa) != e.b_fa || int'(b_fb) != e.b_fb || b_sbf != e.b_sbf) begin
            n_err++;
            $display("FAIL vec%0d_dutB: got fa=%0d fb=%0d sbf=%0d, want fa=%0d fb=%0d sbf=%0d",
                     e.idx, b_fa, b_fb, b_sbf, e.b_fa, e.b_fb, e.b_sbf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int   cnt_a, cnt_b;
        vec_t q;
        //       rst idv irn irm urn urm xrn xrm wr rd ld br   afa afb asbf  bfa bfb bsbf
        vt[0]  = '{1, 1, 5, 0, 1, 0, 5, 0, 1, 5, 1, 1,    0, 0, 0,    0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0,    1, 0, 0,    1, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,    0, 2, 0,    0, 2, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,    0, 0, 0,    3, 3, 0};
        vt[6]  = '{0, 1, 2, 0, 1, 0, 0, 0, 1, 2, 1, 0,    0, 0, 6,    0, 0, 6};
        vt[7]  = '{0, 1, 2, 0, 1, 0, 2, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 6};
        vt[8]  = '{0, 1, 7, 0, 1, 0, 2, 0, 1, 3, 0, 0,    2, 0, 0,    0, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0,    0, 1, 0,    3, 1, 0};
        vt[10] = '{0, 1, 4, 0, 1, 0, 0, 0, 1, 4, 1, 1,    0, 0, 3,    0, 0, 3};
        vt[11] = '{0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0,   0, 0, 0,    0, 0, 0};
        vt[13] = '{0, 1, 31, 31, 1, 1, 31, 4, 1, 31, 1, 0, 0, 0, 0,   0, 3, 0};
        vt[14] = '{0, 0, 0, 6, 0, 1, 0, 0, 1, 6, 1, 0,    0, 0, 0,    0, 0, 0};
        vt[15] = '{0, 1, 7, 7, 0, 1, 6, 6, 1, 7, 1, 0,    0, 0, 6,    0, 0, 6};
        vt[16] = '{0, 0, 0, 0, 0, 0, 6, 7, 0, 0, 0, 0,    2, 0, 0,    0, 0, 6};
        vt[17] = '{0, 0, 0, 0, 0, 0, 7, 6, 0, 0, 0, 0,    2, 0, 0,    0, 3, 0};
        vt[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[20] = '{0, 0, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0,    1, 1, 0,    1, 1, 0};
        vt[21] = '{0, 1, 9, 0, 1, 0, 0, 0, 1, 9, 1, 0,    0, 0, 6,    0, 0, 6};
        vt[22] = '{1, 1, 9, 0, 1, 0, 8, 8, 1, 9, 1, 0,    0, 0, 0,    0, 0, 0};
        vt[23] = '{0, 1, 9, 0, 1, 0, 9, 8, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0};
        vt[24] = '{0, 1, 10, 0, 1, 0, 0, 0, 1, 10, 1, 0,  0, 0, 6,    0, 0, 6};
        vt[25] = '{0, 1, 10, 0, 1, 0, 0, 0, 1, 30, 0, 1,  0, 0, 3,    0, 0, 3};
        vt[26] = '{0, 0, 0, 0, 0, 0, 30, 10, 0, 0, 0, 0,  1, 2, 0,    1, 0, 0};

        q = vt[1];
        drive(q);
        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            sb.push_back('{i, vt[i].a_fa, vt[i].a_fb, vt[i].a_sbf,
                           vt[i].b_fa, vt[i].b_fb, vt[i].b_sbf});
            @(negedge clk);
            check_pop();
        end

        // Load-use stall length: one reset cycle, one hit, then bubbles with ID held.
        q = vt[1];
        @(posedge clk); #1; drive(q);
        q = '{0, 1, 12, 0, 1, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0};
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            drive(q);
            @(negedge clk);
            cnt_a += int'(a_st);
            cnt_b += int'(b_st);
            if (c == 0) check_int("hit_bubble_a", int'(a_bu), 1);
            q = '{0, 1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end
        check_int("stall_len_lat1", cnt_a, 1);
        check_int("stall_len_lat2", cnt_b, 2);
`ifdef HAZ_PERF_CNT_EN
        check_int("perf_stall_a", int'(a_sc), 1);
        check_int("perf_stall_b", int'(b_sc), 2);
        check_int("perf_flush_a", int'(a_fc), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
